uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameter CLK_PER_BIT, default 5208, clock cycles per UART bit (9600 baud at 50 MHz clock); legal range 16 and above.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 start  input  1  transmit request; sampled high for one or more cycles.
REQ-006 data_in  input  8  byte to transmit; captured on an accepted start.
REQ-007 rx_in  input  1  serial receive line, asynchronous to clk, idle high.
REQ-008 data_out  output  8  last correctly received byte.
REQ-009 done  output  1  one-cycle pulse when a byte has been received.
REQ-010 tx_out  output  1  serial transmit line, idle high.
REQ-011 busy  output  1  transmitter is sending a frame.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, with each bit lasting exactly CLK_PER_BIT clocks.
REQ-013 The transmitter SHALL be an FSM with states IDLE, START, DATA, STOP.
REQ-014 In IDLE with start=1, the transmitter SHALL latch data_in, enter START, and drive tx_out=0 from the next clock edge.
REQ-015 busy SHALL go high on the edge that accepts start and stay high through the end of the stop bit.
REQ-016 busy SHALL return low on the edge where STOP completes and the FSM re-enters IDLE; total busy time is 10*CLK_PER_BIT clocks.
REQ-017 start asserted while busy=1 SHALL be ignored; data_in changes during a frame SHALL have no effect.
REQ-018 If start is held high continuously, a new frame SHALL begin on the first IDLE cycle, giving back-to-back frames with no gap.
REQ-019 rx_in SHALL pass through a two-flop synchronizer before use.
REQ-020 The receiver SHALL be an FSM with states IDLE, START, DATA, STOP.
REQ-021 Receiver IDLE: a synchronized low on rx_in SHALL move the FSM to START.
REQ-022 Receiver START: at CLK_PER_BIT/2 clocks the line SHALL be re-sampled; if still low, go to DATA, otherwise treat it as a glitch and return to IDLE.
REQ-023 Receiver DATA: sample each data bit every CLK_PER_BIT clocks (bit centre) and shift LSB first into an internal register.
REQ-024 Receiver STOP: sample one CLK_PER_BIT later.
REQ-025 If the stop sample is 1, data_out SHALL update and done SHALL pulse high for exactly one clock on the same edge.
REQ-026 If the stop sample is 0 (framing error), data_out SHALL be unchanged, no done pulse SHALL occur, and the FSM SHALL wait for rx_in high before returning to IDLE.
REQ-027 data_out SHALL hold its value until the next valid frame.
REQ-028 The transmitter and receiver SHALL be independent; simultaneous TX and RX SHALL be supported, and no internal loopback exists.
REQ-029 Counters SHALL be wide enough for CLK_PER_BIT-1 and SHALL wrap to 0 at each bit boundary with no cumulative drift.

Reset
REQ-030 With rst=0, asynchronously: tx_out=1, busy=0, done=0, data_out=8'h00, both FSMs in IDLE, all counters and shift registers cleared.
REQ-031 Reset asserted mid-frame SHALL abort both directions immediately; tx_out SHALL be high in the same cycle as reset.
REQ-032 After reset release, the first start SHALL be accepted at the first rising clk edge at which it is sampled high.

Verification
REQ-033 Loopback (tx_out wired to rx_in), send 0xA5: done pulses once about 9.5*CLK_PER_BIT clocks after start; data_out=0xA5; busy low after 10*CLK_PER_BIT clocks.
REQ-034 Loopback sends of 0x00, 0xFF and 0x01: each byte is received exactly; tx_out waveform is the start bit, then bits LSB first, then the stop bit, with exact bit widths.
REQ-035 Pulse start again mid-frame with data_in=0x3C: the pulse is ignored; only the original byte is transmitted and busy stays a single contiguous pulse.
REQ-036 Hold start high with data_in=0x55: frames are back to back, and busy drops for at most one cycle between frames.
REQ-037 Drive rx_in externally with a frame whose stop bit is 0: no done pulse and data_out unchanged; a following valid frame of 0x5A is received correctly.
REQ-038 Assert rst mid-transmission: tx_out goes to 1 and busy to 0 at once; after release, a send of 0xC3 loops back correctly.

Source files
------------

// File: rtl/uart_top.sv
// uart_top: 8N1 UART with an independent transmitter and receiver.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - transmit request, accepted only while idle
//   data_in  - byte to send, captured when start is accepted
//   rx_in    - serial receive line (asynchronous, idle high)
//   data_out - last byte received with a valid stop bit
//   done     - one-cycle pulse when data_out is updated
//   tx_out   - serial transmit line (idle high)
//   busy     - transmitter is sending a frame
module uart_top #(
    parameter int CLK_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       done,
    output logic       tx_out,
    output logic       busy
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- transmitter ----------------
    state_t          tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_bit, tx_bit_n;
    logic [7:0]      tx_shreg, tx_shreg_n;
    logic            tx_out_n;

    assign busy = (tx_state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_out   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shreg <= tx_shreg_n;
            tx_out   <= tx_out_n;
        end
    end

    // tx_out is registered; the next line level is chosen here so the
    // serial output never glitches on a state decode.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shreg_n = tx_shreg;
        tx_out_n   = tx_out;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                tx_bit_n = '0;
                tx_out_n = 1'b1;
                if (start) begin
                    tx_shreg_n = data_in;
                    tx_state_n = START;
                    tx_out_n   = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = DATA;
                    tx_out_n   = tx_shreg[0];
                end else begin
                    tx_cnt_n = tx_cnt + ONE;
                end
            end
            DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = STOP;
                        tx_out_n   = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shreg_n = {1'b0, tx_shreg[7:1]};
                        tx_out_n   = tx_shreg[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + ONE;
                end
            end
            STOP: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + ONE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic            rx_s1, rx_s2;
    state_t          rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_shreg, rx_shreg_n;
    logic            rx_ferr, rx_ferr_n;
    logic [7:0]      data_out_n;
    logic            done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_ferr  <= 1'b0;
            data_out <= 8'h00;
            done     <= 1'b0;
        end else begin
            rx_s1    <= rx_in;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shreg <= rx_shreg_n;
            rx_ferr  <= rx_ferr_n;
            data_out <= data_out_n;
            done     <= done_n;
        end
    end

    // After the half-bit start check the counter restarts, so every
    // later sample lands one full bit later, at the bit centre.
    // rx_ferr holds STOP after a bad stop bit until the line idles.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        rx_ferr_n  = rx_ferr;
        data_out_n = data_out;
        done_n     = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n  = '0;
                rx_bit_n  = '0;
                rx_ferr_n = 1'b0;
                if (!rx_s2) rx_state_n = START;
            end
            START: begin
                if (rx_cnt == MID) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_s2 ? IDLE : DATA;
                end else begin
                    rx_cnt_n = rx_cnt + ONE;
                end
            end
            DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_n   = '0;
                    rx_shreg_n = {rx_s2, rx_shreg[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + ONE;
                end
            end
            STOP: begin
                if (rx_ferr) begin
                    if (rx_s2) begin
                        rx_ferr_n  = 1'b0;
                        rx_state_n = IDLE;
                    end
                end else if (rx_cnt == LAST) begin
                    rx_cnt_n = '0;
                    if (rx_s2) begin
                        data_out_n = rx_shreg;
                        done_n     = 1'b1;
                        rx_state_n = IDLE;
                    end else begin
                        rx_ferr_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + ONE;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: randomized scoreboard bench for uart_top.
// Ports: none (drives uart_top with loopback or an external rx line).
module tb_uart_top;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       rx_in;
    logic [7:0] data_out;
    logic       done;
    logic       tx_out;
    logic       busy;
    logic       ext_rx;
    logic       loop;

    assign rx_in = loop ? tx_out : ext_rx;

    uart_top #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .rx_in    (rx_in),
        .data_out (data_out),
        .done     (done),
        .tx_out   (tx_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        bit         lat;
        int         acc;
    } rx_item_t;

    rx_item_t   rx_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] last_good;
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Receive scoreboard: every done pops the oldest expected byte.
    always @(negedge clk) begin : rxmon
        rx_item_t it;
        int       l;
        if (rst === 1'b1 && done === 1'b1) begin
            check("rx_done_expected", rx_exp.size() > 0, 1);
            if (rx_exp.size() > 0) begin
                it = rx_exp.pop_front();
                check("rx_data", data_out, it.b);
                if (it.lat) begin
                    l = cyc - it.acc;
                    checks++;
                    if (l < 9*CPB + HALF || l > 9*CPB + HALF + 4) begin
                        errors++;
                        $display("FAIL rx_latency actual=%0d expected=%0d..%0d",
                                 l, 9*CPB + HALF, 9*CPB + HALF + 4);
                    end
                end
            end
        end
    end

    // Transmit monitor: a frame is 10 bits {stop=1, byte, start=0},
    // each exactly CPB clocks, with busy high throughout and low after.
    initial begin : txmon
        logic       prev;
        logic [7:0] b;
        logic [9:0] fr;
        int         bad;
        bit         ab;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && prev === 1'b1 && tx_out === 1'b0) begin
                check("tx_frame_expected", tx_exp.size() > 0, 1);
                b = 8'h00;
                if (tx_exp.size() > 0) b = tx_exp.pop_front();
                fr  = {1'b1, b, 1'b0};
                bad = 0;
                ab  = 0;
                for (int i = 0; i < 10*CPB; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b1) begin
                        ab = 1;
                        break;
                    end
                    if (tx_out !== fr[i/CPB] || busy !== 1'b1) bad++;
                end
                if (!ab) begin
                    check("tx_wave_bad_samples", bad, 0);
                    @(negedge clk);
                    if (rst === 1'b1) begin
                        check("tx_busy_end", busy, 0);
                        check("tx_idle_level", tx_out, 1);
                    end
                end
            end
            prev = tx_out;
        end
    end

    // Called at a negedge; waits for the transmitter to be free.
    task automatic send(input logic [7:0] b, input bit lat);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20*CPB) begin
            @(negedge clk);
            n++;
        end
        check("send_idle", busy, 0);
        data_in = b;
        start   = 1'b1;
        tx_exp.push_back(b);
        @(negedge clk);
        start = 1'b0;
        if (loop) begin
            rx_exp.push_back('{b, lat, cyc});
            last_good = b;
        end
        check("busy_rise", busy, 1);
        data_in = 8'($urandom);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        if (stopb) begin
            rx_exp.push_back('{b, 1'b0, 0});
            last_good = b;
        end
        for (int i = 0; i < 10; i++) begin
            ext_rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        ext_rx = 1'b1;
        repeat (2*CPB) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rx_exp.size() != 0 || tx_exp.size() != 0 || busy === 1'b1)
               && n < 30*CPB) begin
            @(negedge clk);
            n++;
        end
        check("drain", rx_exp.size() + tx_exp.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        logic [7:0] fixed[4];
        logic [7:0] b;
        int         rises;
        int         n;
        logic       pb;

        rst       = 1'b0;
        start     = 1'b0;
        data_in   = 8'h00;
        ext_rx    = 1'b1;
        loop      = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data_out", data_out, 8'h00);

        rst = 1'b1;
        send(8'hA5, 1'b1);
        wait_idle();
        check("a5_data_out", data_out, 8'hA5);

        fixed[0] = 8'h00;
        fixed[1] = 8'hFF;
        fixed[2] = 8'h01;
        fixed[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            send(fixed[i], 1'b1);
            wait_idle();
        end

        for (int i = 0; i < 10; i++) begin
            send(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 2*CPB)) @(negedge clk);
            wait_idle();
        end

        // start pulse mid-frame must be ignored
        send(8'hE7, 1'b1);
        repeat (3*CPB) @(negedge clk);
        data_in = 8'h3C;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("ignore_data_out", data_out, 8'hE7);

        // start held high: back-to-back frames
        data_in = 8'h55;
        start   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_exp.push_back(8'h55);
            rx_exp.push_back('{8'h55, 1'b0, 0});
        end
        last_good = 8'h55;
        rises = 0;
        n     = 0;
        pb    = busy;
        while (rises < 3 && n < 40*CPB) begin
            @(negedge clk);
            if (busy === 1'b1 && pb === 1'b0) rises++;
            pb = busy;
            n++;
        end
        start = 1'b0;
        check("held_frames", rises, 3);
        wait_idle();

        // external receive line: glitch, framing error, valid frames
        loop = 1'b0;
        ext_rx = 1'b0;
        repeat (3) @(negedge clk);
        ext_rx = 1'b1;
        repeat (2*CPB) @(negedge clk);
        check("glitch_hold", data_out, last_good);

        drive_frame(8'($urandom), 1'b0);
        check("ferr_hold", data_out, last_good);
        drive_frame(8'h5A, 1'b1);
        wait_idle();
        check("after_ferr", data_out, 8'h5A);

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            drive_frame(b, ($urandom_range(0, 3) != 0));
            check("ext_data_out", data_out, last_good);
        end
        wait_idle();

        // simultaneous transmit and receive
        for (int i = 0; i < 3; i++) begin
            fork
                send(8'($urandom), 1'b0);
                drive_frame(8'($urandom), 1'b1);
            join
            wait_idle();
            check("duplex_data_out", data_out, last_good);
        end

        // reset mid-transmission
        loop = 1'b1;
        send(8'h96, 1'b0);
        repeat (4*CPB) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_tx_out", tx_out, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_data_out", data_out, 8'h00);
        tx_exp.delete();
        rx_exp.delete();
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(8'hC3, 1'b1);
        wait_idle();
        check("post_reset_data_out", data_out, 8'hC3);

        check("final_data_out", data_out, last_good);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
